// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handoff and redirect inputs.
// The master side is the fetch controller; the slave side is memory/decode/redirect logic.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_SIZE = 32,
  parameter int INST_LEN  = 32
);

  logic                 imem_req;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic                 imem_ready;
  logic [INST_LEN-1:0]  imem_rdata;

  logic                 inst_valid;
  logic                 inst_ready;
  logic [INST_LEN-1:0]  inst;
  logic [ADDR_SIZE-1:0] inst_pc;

  logic                 br_valid;
  logic [ADDR_SIZE-1:0] br_target;
  logic                 trap_valid;
  logic [ADDR_SIZE-1:0] trap_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ready, imem_rdata, inst_ready,
    input  br_valid, br_target, trap_valid, trap_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ready, imem_rdata, inst_ready,
    output br_valid, br_target, trap_valid, trap_target
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding imem request, trap > branch > pc+4 selection,
// and a single-entry holding register that back-pressures fetch while decode stalls.
module pc_fetch_ctrl #(
  parameter int                   ADDR_SIZE    = 32,
  parameter int                   INST_LEN     = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pc_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] redirPc_q, redirPc_d;
  logic [INST_LEN-1:0]  inst_q, inst_d;

  logic                 redirValid;
  logic [ADDR_SIZE-1:0] redirRaw;
  logic [ADDR_SIZE-1:0] redirTarget;
  logic [ADDR_SIZE-1:0] pcSeq;

  // Trap wins over branch; redirect targets are forced word-aligned.
  assign redirValid  = bus.trap_valid | bus.br_valid;
  assign redirRaw    = bus.trap_valid ? bus.trap_target : bus.br_target;
  assign redirTarget = redirRaw & ~ADDR_SIZE'(3);
  assign pcSeq       = pc_q + ADDR_SIZE'(4);

  assign bus.imem_req   = (state_q == REQ) || (state_q == DROP);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VECTOR;
      redirPc_q <= RESET_VECTOR;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      redirPc_q <= redirPc_d;
      inst_q    <= inst_d;
    end
  end

  // DROP keeps the old address on the bus until the abandoned request completes,
  // parking the pending target in redirPc_q meanwhile.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redirPc_d = redirPc_q;
    inst_d    = inst_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirValid) begin
          pc_d = redirTarget;
        end
      end
      REQ: begin
        if (redirValid && bus.imem_ready) begin
          pc_d = redirTarget;
        end else if (redirValid) begin
          redirPc_d = redirTarget;
          state_d   = DROP;
        end else if (bus.imem_ready) begin
          inst_d  = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      DROP: begin
        if (bus.imem_ready) begin
          pc_d    = redirValid ? redirTarget : redirPc_q;
          state_d = REQ;
        end else if (redirValid) begin
          redirPc_d = redirTarget;
        end
      end
      HOLD: begin
        if (redirValid) begin
          pc_d    = redirTarget;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pcSeq;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences the program counter for the instruction-fetch stage. Owns the PC register and issues one instruction-memory request at a time over a req/ready handshake. Selects the next PC with priority trap > branch redirect > sequential (+4), and hands fetched instructions to decode over a valid/ready handshake. Sits between the instruction memory port and the decode stage.

Parameters:
ADDR_SIZE, 32, width of PC and memory address
INST_LEN, 32, instruction word width
RESET_VECTOR, 32'h80000000, PC value loaded on reset

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imem_req  output  1  fetch request, held until imem_ready
imem_addr  output  ADDR_SIZE  fetch address, stable while imem_req=1
imem_ready  input  1  memory response valid this cycle; completes the request
imem_rdata  input  INST_LEN  instruction word, valid with imem_ready
inst_valid  output  1  held instruction available to decode
inst_ready  input  1  decode accepts the instruction
inst  output  INST_LEN  held instruction word
inst_pc  output  ADDR_SIZE  address of held instruction
br_valid  input  1  branch/jump redirect request
br_target  input  ADDR_SIZE  redirect target
trap_valid  input  1  trap redirect request
trap_target  input  ADDR_SIZE  trap vector

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, redir_pc=RESET_VECTOR, state=IDLE, imem_req=0, inst_valid=0, inst=0. imem_addr and inst_pc equal pc at all times.
- Redirect: active when trap_valid|br_valid. Target is trap_target if trap_valid, else br_target. Bits [1:0] of the target are forced to 0.
- Sequential next PC: pc+4, modulo 2^ADDR_SIZE. 32'hFFFFFFFC wraps to 0.
- IDLE: imem_req=0. Unconditionally goes to REQ on the next cycle. Redirects in IDLE load pc with the target.
- REQ: imem_req=1.
  - imem_ready, no redirect: latch inst<=imem_rdata, go to HOLD. Fetch-to-inst_valid latency is 1 cycle after the ready cycle.
  - Redirect with imem_ready in the same cycle: discard the response, pc<=target, stay in REQ (new request next cycle).
  - Redirect without imem_ready: redir_pc<=target, go to DROP. The address must stay stable, so pc is unchanged.
- DROP: imem_req=1 at the old pc until imem_ready.
  - Further redirects overwrite redir_pc (trap priority applies).
  - On imem_ready: discard the data. pc<=redirect target if a redirect is present that cycle, else redir_pc. Go to REQ.
- HOLD: imem_req=0, inst_valid=1. inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
  - inst_ready, no redirect: pc<=pc+4, go to REQ, inst_valid=0 next cycle.
  - Redirect (with or without inst_ready): the held instruction is killed. The handshake that cycle does not count as an accept. pc<=target, go to REQ.
- At most one request is outstanding. No new request issues while inst_valid=1, so the decode stall is fully back-pressured.
- imem_ready is ignored outside REQ/DROP.
- Reset asserted mid-request: the outstanding request is abandoned. The bench's memory model must also reset.
- Encoding: states IDLE, REQ, DROP, HOLD as a 2-bit register.

Test Plan:
- Reset release, memory returns ready one cycle after each req, inst_ready=1 always → imem_addr sequence 80000000, 80000004, 80000008. inst_valid pulses with inst_pc matching. First imem_req is in the 2nd cycle after reset deasserts.
- Decode stall: hold inst_ready=0 for 5 cycles in HOLD → inst, inst_pc, inst_valid=1 stable, imem_req=0. Release → next request at inst_pc+4.
- Redirect during wait: req at 80000010, memory delays 3 cycles, br_valid with target 80000100 in cycle 1 → imem_addr stays 80000010 until ready. Data dropped (no inst_valid). Next req at 80000100.
- Simultaneous trap and branch in HOLD, trap_target 80000200, br_target 80000300, inst_ready=1 → instruction not accepted, next req 80000200.
- Misaligned target 80000402 → next req 80000400. pc FFFFFFFC accepted → next req 00000000.
- Assert reset during DROP → outputs return to reset values immediately (async). After release, fetch restarts at 80000000.
